cmd_frame_decoder: RTL

Byte-level command frame decoder in the REF_CLK domain. It consumes the synchronized UART receive byte stream (parallel byte plus single-cycle valid) and assembles complete command frames: register write, register read, ALU with operands, ALU without operands. Each completed frame is presented as one decoded command on a valid/ready interface to the control logic that drives the register file and ALU. It also detects unknown opcodes, stalled frames and bytes lost while a command is held.

---
 rtl/cmd_pkg.sv | 29 ++
 rtl/cmd_frame_decoder_frame_timer.sv | 39 +++
 rtl/cmd_frame_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the command frame decoder: opcode bytes,
// decoded command types and decoder FSM states.
package cmd_pkg;

  localparam int unsigned OP_W = 8;

  localparam logic [OP_W-1:0] OP_WR      = 8'hAA;
  localparam logic [OP_W-1:0] OP_RD      = 8'hBB;
  localparam logic [OP_W-1:0] OP_ALU     = 8'hCC;
  localparam logic [OP_W-1:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    WRITE   = 2'd0,
    READ    = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_WDATA = 3'd2,
    GET_OPA   = 3'd3,
    GET_OPB   = 3'd4,
    GET_FUN   = 3'd5,
    HOLD      = 3'd6
  } dec_state_e;

endpackage

// File: rtl/cmd_frame_decoder_frame_timer.sv
// Inter-byte idle timer for frame assembly.
// Ports: clk, rst (sync, active-high), clr (force count to 0),
//        en (count one idle cycle), expire_c (combinational: this idle
//        cycle is the TIMEOUT-th one; the count wraps back to 0).
module frame_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear (byte accepted) on the limit cycle wins over expiry.
  assign expire_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles UART byte frames into decoded commands on a valid/ready port.
// Ports: CLK, RST (sync, active-high); RX_P_DATA/RX_D_VLD byte stream in;
//        CMD_VLD/CMD_RDY handshake with CMD_TYPE/ADDR/DATA_A/DATA_B/FUN out;
//        FRAME_ERR, TO_ERR, OVERRUN one-cycle error pulses.
module cmd_frame_decoder
  import cmd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADD_WIDTH = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic                 CMD_RDY,
  output logic                 CMD_VLD,
  output logic [1:0]           CMD_TYPE,
  output logic [ADD_WIDTH-1:0] CMD_ADDR,
  output logic [WIDTH-1:0]     CMD_DATA_A,
  output logic [WIDTH-1:0]     CMD_DATA_B,
  output logic [ADD_WIDTH-1:0] CMD_FUN,
  output logic                 FRAME_ERR,
  output logic                 TO_ERR,
  output logic                 OVERRUN
);

  dec_state_e           state_q, state_d;
  cmd_type_e            op_q, op_d;
  cmd_type_e            cmd_type_q, cmd_type_d;
  // Partial fields are shadowed so an aborted frame never disturbs CMD_*.
  logic [ADD_WIDTH-1:0] sh_addr_q, sh_addr_d;
  logic [WIDTH-1:0]     sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [ADD_WIDTH-1:0] cmd_addr_q, cmd_addr_d, cmd_fun_q, cmd_fun_d;
  logic [WIDTH-1:0]     cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
  logic                 cmd_vld_q, cmd_vld_d;
  logic                 frame_err_q, frame_err_d;
  logic                 to_err_q, to_err_d;
  logic                 overrun_q, overrun_d;
  logic                 in_get_c, expire_c;
  logic [ADD_WIDTH-1:0] byte_lo_c;

  assign in_get_c  = (state_q != IDLE) && (state_q != HOLD);
  assign byte_lo_c = RX_P_DATA[ADD_WIDTH-1:0];

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (RX_D_VLD || !in_get_c),
    .en       (in_get_c && !RX_D_VLD),
    .expire_c (expire_c)
  );

  // Next-state and field update logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cmd_type_d  = cmd_type_q;
    sh_addr_d   = sh_addr_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_fun_d   = cmd_fun_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    cmd_vld_d   = cmd_vld_q;
    frame_err_d = 1'b0;
    to_err_d    = expire_c;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(OP_WR)) begin
            op_d    = WRITE;
            state_d = GET_ADDR;
          end else if (RX_P_DATA == WIDTH'(OP_RD)) begin
            op_d    = READ;
            state_d = GET_ADDR;
          end else if (RX_P_DATA == WIDTH'(OP_ALU)) begin
            op_d    = ALU_OP;
            state_d = GET_OPA;
          end else if (RX_P_DATA == WIDTH'(OP_ALU_NOP)) begin
            op_d    = ALU_NOP;
            state_d = GET_FUN;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (RX_D_VLD) begin
          if (op_q == READ) begin
            cmd_addr_d = byte_lo_c;
            cmd_type_d = op_q;
            cmd_vld_d  = 1'b1;
            state_d    = HOLD;
          end else begin
            sh_addr_d = byte_lo_c;
            state_d   = GET_WDATA;
          end
        end
      end
      GET_WDATA: begin
        if (RX_D_VLD) begin
          cmd_addr_d = sh_addr_q;
          cmd_a_d    = RX_P_DATA;
          cmd_type_d = op_q;
          cmd_vld_d  = 1'b1;
          state_d    = HOLD;
        end
      end
      GET_OPA: begin
        if (RX_D_VLD) begin
          sh_a_d  = RX_P_DATA;
          state_d = GET_OPB;
        end
      end
      GET_OPB: begin
        if (RX_D_VLD) begin
          sh_b_d  = RX_P_DATA;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          if (op_q == ALU_OP) begin
            cmd_a_d = sh_a_q;
            cmd_b_d = sh_b_q;
          end
          cmd_fun_d  = byte_lo_c;
          cmd_type_d = op_q;
          cmd_vld_d  = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Any byte here is dropped, never reinterpreted as an opcode.
        overrun_d = RX_D_VLD;
        if (CMD_RDY) begin
          cmd_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_vld_d = 1'b0;
      end
    endcase

    if (expire_c) begin
      state_d = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      op_q        <= WRITE;
      cmd_type_q  <= WRITE;
      sh_addr_q   <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      cmd_addr_q  <= '0;
      cmd_fun_q   <= '0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
      to_err_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_type_q  <= cmd_type_d;
      sh_addr_q   <= sh_addr_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_fun_q   <= cmd_fun_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
      to_err_q    <= to_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign CMD_VLD    = cmd_vld_q;
  assign CMD_TYPE   = cmd_type_q;
  assign CMD_ADDR   = cmd_addr_q;
  assign CMD_DATA_A = cmd_a_q;
  assign CMD_DATA_B = cmd_b_q;
  assign CMD_FUN    = cmd_fun_q;
  assign FRAME_ERR  = frame_err_q;
  assign TO_ERR     = to_err_q;
  assign OVERRUN    = overrun_q;

endmodule
